fetch_unit: RTL and testbench

Instruction-fetch control stage between the PC register and the IF/ID boundary of the 5-stage RISC-V pipeline. It consumes the current `PC`, issues in-order requests to instruction memory over a valid/ready handshake, and buffers returned instructions in a small queue presented to decode. It drives `PC_Next` back to the PC register, advancing it only when a request is accepted. It also handles EX-stage branch/jump redirects by flushing the queue and discarding stale in-flight responses.

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus.
//   master (fetch side): drives imem_req_valid/imem_req_addr, samples
//                        imem_req_ready, imem_rsp_valid, imem_rsp_data.
//   slave  (memory side): the reverse.
// Responses return in request order, one per cycle at most, with no backpressure.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch control between the PC register and IF/ID.
// Issues in-order fetches to instruction memory, pairs each response with its
// address and buffers {PC, instruction} in a DEPTH-entry queue toward decode.
// EX redirects flush the queue and discard responses still in flight.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   PC / PC_Next                current fetch PC / next value for the PC register
//   imem                        memory request/response bus (master side)
//   redirect_valid/_target      EX-stage branch/jump redirect
//   InstrD, PCD, PCPlus4D       head entry toward decode
//   valid_d / ready_d           decode handshake
module fetch_unit #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         PC,
    output logic [31:0]         PC_Next,
    fetch_unit_if.master        imem,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_target,
    output logic [31:0]         InstrD,
    output logic [31:0]         PCD,
    output logic [31:0]         PCPlus4D,
    output logic                valid_d,
    input  logic                ready_d
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    // Address FIFO: one entry per outstanding request, stale ones included.
    logic [31:0]     af_mem [DEPTH];
    logic [PtrW-1:0] af_wr_q, af_wr_d, af_rd_q, af_rd_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

    // Decode queue.
    logic [31:0]     q_addr [DEPTH];
    logic [31:0]     q_data [DEPTH];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic [CntW:0]   credit_used;
    logic            fire, rsp, discard, enq, deq, has_head;

    always_comb begin
        // Credits cover both in-flight requests and queued entries, so the
        // queue can never be asked to take a response it has no room for.
        credit_used         = {1'b0, outstanding_q} + {1'b0, count_q};
        imem.imem_req_valid = !rst && !redirect_valid && (credit_used < (CntW + 1)'(DEPTH));
        imem.imem_req_addr  = PC;
        fire                = imem.imem_req_valid && imem.imem_req_ready;
        rsp                 = imem.imem_rsp_valid;
        discard             = redirect_valid || (drop_cnt_q != '0);
        enq                 = rsp && !discard;
        has_head            = (count_q != '0);
        valid_d             = has_head && !redirect_valid;
        deq                 = valid_d && ready_d;

        if (rst) begin
            PC_Next = 32'h0;
        end else if (redirect_valid) begin
            PC_Next = {redirect_target[31:2], 2'b00};
        end else if (fire) begin
            PC_Next = PC + 32'd4;
        end else begin
            PC_Next = PC;
        end

        af_wr_d       = af_wr_q + PtrW'(fire);
        af_rd_d       = af_rd_q + PtrW'(rsp);
        outstanding_d = outstanding_q + CntW'(fire) - CntW'(rsp);

        // Everything in flight at a redirect is stale; a response arriving in
        // the redirect cycle itself is dropped right away and not counted.
        if (redirect_valid) begin
            drop_cnt_d = outstanding_q - CntW'(rsp);
        end else if (rsp && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CntW'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        if (redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PtrW'(deq);
            tail_d  = tail_q + PtrW'(enq);
            count_d = count_q + CntW'(enq) - CntW'(deq);
        end

        // Gated so the head reads as zero while the queue is empty (incl. reset).
        InstrD   = has_head ? q_data[head_q] : 32'h0;
        PCD      = has_head ? q_addr[head_q] : 32'h0;
        PCPlus4D = has_head ? (q_addr[head_q] + 32'd4) : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            af_wr_q       <= '0;
            af_rd_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            af_wr_q       <= af_wr_d;
            af_rd_q       <= af_rd_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the counters.
    always_ff @(posedge clk) begin
        if (fire) begin
            af_mem[af_wr_q] <= PC;
        end
        if (enq && !rst) begin
            q_addr[tail_q] <= af_mem[af_rd_q];
            q_data[tail_q] <= imem.imem_rsp_data;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(enq && (count_q == CntW'(DEPTH))));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. Models the PC register and
// an in-order instruction memory, and predicts decode-side behaviour from
// epochs: a response is delivered only if its request was issued after the
// most recent redirect.
module tb_fetch_unit;
    localparam int unsigned Depth = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, redirect_valid, ready_d, valid_d;
    logic [31:0] PC, PC_Next, redirect_target, InstrD, PCD, PCPlus4D;

    fetch_unit_if imem_bus ();

    fetch_unit #(.DEPTH(Depth)) dut (
        .clk            (clk),
        .rst            (rst),
        .PC             (PC),
        .PC_Next        (PC_Next),
        .imem           (imem_bus),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
        .valid_d        (valid_d),
        .ready_d        (ready_d)
    );

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned lat_min  = 1;
    int unsigned lat_max  = 1;

    // Memory environment.
    logic [31:0] mem_addr [$];
    int unsigned mem_due  [$];
    int unsigned last_due = 0;

    // Reference model.
    logic [31:0] pend_addr  [$];
    int unsigned pend_epoch [$];
    logic [31:0] dq         [$];
    int unsigned epoch = 0;

    logic        exp_req_valid, exp_valid_d;
    logic [31:0] exp_pcd, exp_pc_next;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Drive memory response for this cycle, form predictions, move to negedge.
    task automatic settle();
        if (mem_due.size() != 0 && mem_due[0] <= cyc) begin
            imem_bus.imem_rsp_valid = 1'b1;
            imem_bus.imem_rsp_data  = instr_of(mem_addr[0]);
        end else begin
            imem_bus.imem_rsp_valid = 1'b0;
            imem_bus.imem_rsp_data  = $urandom();
        end
        exp_req_valid = !rst && !redirect_valid && ((pend_addr.size() + dq.size()) < Depth);
        exp_valid_d   = (dq.size() != 0) && !redirect_valid;
        exp_pcd       = (dq.size() != 0) ? dq[0] : 32'h0;
        if (rst) exp_pc_next = 32'h0;
        else if (redirect_valid) exp_pc_next = redirect_target & 32'hFFFF_FFFC;
        else if (exp_req_valid && imem_bus.imem_req_ready) exp_pc_next = PC + 32'd4;
        else exp_pc_next = PC;
        @(negedge clk);
    endtask

    // Cross the clock edge and update environment and model.
    task automatic advance();
        logic        dut_fire, got_rsp, exp_fire, exp_deq;
        logic [31:0] nxt, a;
        int unsigned e, due;
        dut_fire = imem_bus.imem_req_valid && imem_bus.imem_req_ready;
        got_rsp  = imem_bus.imem_rsp_valid;
        exp_fire = exp_req_valid && imem_bus.imem_req_ready;
        exp_deq  = exp_valid_d && ready_d;
        nxt      = PC_Next;
        @(posedge clk);
        #1;
        if (rst) begin
            mem_addr.delete();
            mem_due.delete();
            pend_addr.delete();
            pend_epoch.delete();
            dq.delete();
            last_due = cyc;
            epoch++;
        end else begin
            if (got_rsp && mem_addr.size() != 0) begin
                a   = mem_addr.pop_front();
                due = mem_due.pop_front();
            end
            if (dut_fire) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_addr.push_back(PC);
                mem_due.push_back(due);
            end
            if (exp_deq) a = dq.pop_front();
            if (redirect_valid) begin
                dq.delete();
                epoch++;
            end
            if (got_rsp && pend_addr.size() != 0) begin
                a = pend_addr.pop_front();
                e = pend_epoch.pop_front();
                if (e == epoch) dq.push_back(a);
            end
            if (exp_fire) begin
                pend_addr.push_back(PC);
                pend_epoch.push_back(epoch);
            end
        end
        PC = nxt;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        ready_d = 1'b0;
        imem_bus.imem_req_ready = 1'b0;
        repeat (2) begin
            settle();
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic run_until_valid(output logic found, output logic [31:0] pcd,
                                   output logic [31:0] instr, output logic [31:0] p4);
        found = 1'b0;
        pcd = 32'h0;
        instr = 32'h0;
        p4 = 32'h0;
        for (int i = 0; i < 30 && !found; i++) begin
            settle();
            if (valid_d === 1'b1) begin
                found = 1'b1;
                pcd = PCD;
                instr = InstrD;
                p4 = PCPlus4D;
            end
            advance();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        PC = 32'h40;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        ready_d = 1'b0;
        imem_bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (PC_Next !== 32'h0 || imem_bus.imem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_pc_req cyc=%0d PC_Next=%h req_valid=%b required 0/0",
                         cyc, PC_Next, imem_bus.imem_req_valid);
            end
            if (i == 1) begin
                checks++;
                if (valid_d !== 1'b0 || InstrD !== 32'h0 || PCD !== 32'h0 || PCPlus4D !== 32'h0) begin
                    failures++;
                    $display("FAIL reset_outputs valid_d=%b InstrD=%h PCD=%h PCPlus4D=%h required 0",
                             valid_d, InstrD, PCD, PCPlus4D);
                end
            end
            advance();
            if (i == 0) PC = 32'h40;
        end
        rst = 1'b0;
        ready_d = 1'b1;
        settle();
        checks++;
        if (imem_bus.imem_req_valid !== 1'b1 || imem_bus.imem_req_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_first_req req_valid=%b addr=%h required 1/00000000",
                     imem_bus.imem_req_valid, imem_bus.imem_req_addr);
        end
        advance();
    endtask

    task automatic test_stream();
        int          first_fire, first_valid, nvalid;
        logic [31:0] want;
        do_reset();
        lat_min = 1;
        lat_max = 1;
        ready_d = 1'b1;
        imem_bus.imem_req_ready = 1'b1;
        first_fire = -1;
        first_valid = -1;
        nvalid = 0;
        want = 32'h0;
        for (int i = 0; i < 30; i++) begin
            settle();
            if (first_fire < 0 && imem_bus.imem_req_valid === 1'b1) first_fire = i;
            if (valid_d === 1'b1) begin
                if (first_valid < 0) first_valid = i;
                nvalid++;
                checks++;
                if (PCD !== want || InstrD !== instr_of(want) || PCPlus4D !== want + 32'd4) begin
                    failures++;
                    $display("FAIL stream_entry cyc=%0d PCD=%h InstrD=%h PCPlus4D=%h required PCD=%h",
                             cyc, PCD, InstrD, PCPlus4D, want);
                end
                want += 32'd4;
            end
            advance();
        end
        checks++;
        if (first_fire < 0 || first_valid - first_fire != 2) begin
            failures++;
            $display("FAIL stream_latency first_fire=%0d first_valid=%0d required gap 2",
                     first_fire, first_valid);
        end
        checks++;
        if (nvalid != 30 - first_valid) begin
            failures++;
            $display("FAIL stream_rate valid_cycles=%0d required %0d", nvalid, 30 - first_valid);
        end
    endtask

    task automatic test_stall_fill();
        int          fires, accepts, drained;
        logic [31:0] want;
        do_reset();
        lat_min = 1;
        lat_max = 1;
        ready_d = 1'b1;
        imem_bus.imem_req_ready = 1'b1;
        fires = 0;
        accepts = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) ready_d = 1'b0;
            settle();
            if (i >= 8) begin
                checks++;
                if (imem_bus.imem_req_valid !== 1'b0 || PC_Next !== PC) begin
                    failures++;
                    $display("FAIL stall_halt cyc=%0d req_valid=%b PC_Next=%h required 0/%h",
                             cyc, imem_bus.imem_req_valid, PC_Next, PC);
                end
            end
            if (imem_bus.imem_req_valid === 1'b1) fires++;
            if (valid_d === 1'b1 && ready_d) accepts++;
            advance();
        end
        checks++;
        if (fires - accepts != int'(Depth)) begin
            failures++;
            $display("FAIL stall_credit in_flight=%0d required %0d", fires - accepts, Depth);
        end
        want = 32'(accepts * 4);
        ready_d = 1'b1;
        drained = 0;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (valid_d === 1'b1) begin
                checks++;
                if (PCD !== want || InstrD !== instr_of(want)) begin
                    failures++;
                    $display("FAIL stall_drain PCD=%h InstrD=%h required PCD=%h", PCD, InstrD, want);
                end
                want += 32'd4;
                drained++;
            end
            advance();
        end
        checks++;
        if (drained < int'(Depth)) begin
            failures++;
            $display("FAIL stall_drain_count drained=%0d required >=%0d", drained, Depth);
        end
    endtask

    task automatic test_redirect_flush();
        logic        found;
        logic [31:0] pcd, instr, p4;
        do_reset();
        lat_min = 3;
        lat_max = 3;
        ready_d = 1'b1;
        imem_bus.imem_req_ready = 1'b1;
        repeat (2) begin
            settle();
            advance();
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        settle();
        checks++;
        if (imem_bus.imem_req_valid !== 1'b0 || PC_Next !== 32'h100 || valid_d !== 1'b0) begin
            failures++;
            $display("FAIL flush_redirect_cycle req_valid=%b PC_Next=%h valid_d=%b required 0/100/0",
                     imem_bus.imem_req_valid, PC_Next, valid_d);
        end
        advance();
        redirect_valid = 1'b0;
        settle();
        checks++;
        if (imem_bus.imem_req_valid !== 1'b1 || imem_bus.imem_req_addr !== 32'h100) begin
            failures++;
            $display("FAIL flush_resume req_valid=%b addr=%h required 1/00000100",
                     imem_bus.imem_req_valid, imem_bus.imem_req_addr);
        end
        advance();
        run_until_valid(found, pcd, instr, p4);
        checks++;
        if (!found || pcd !== 32'h100 || instr !== instr_of(32'h100)) begin
            failures++;
            $display("FAIL flush_first_valid found=%b PCD=%h InstrD=%h required PCD=00000100",
                     found, pcd, instr);
        end
    endtask

    task automatic test_simultaneous();
        logic        found;
        logic [31:0] pcd, instr, p4;
        do_reset();
        lat_min = 2;
        lat_max = 2;
        ready_d = 1'b1;
        imem_bus.imem_req_ready = 1'b1;
        repeat (2) begin
            settle();
            advance();
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h200;
        settle();
        checks++;
        if (imem_bus.imem_req_valid !== 1'b0 || PC_Next !== 32'h200 || valid_d !== 1'b0) begin
            failures++;
            $display("FAIL simul_redirect_cycle req_valid=%b PC_Next=%h valid_d=%b required 0/200/0",
                     imem_bus.imem_req_valid, PC_Next, valid_d);
        end
        advance();
        redirect_valid = 1'b0;
        run_until_valid(found, pcd, instr, p4);
        checks++;
        if (!found || pcd !== 32'h200 || instr !== instr_of(32'h200)) begin
            failures++;
            $display("FAIL simul_first_valid found=%b PCD=%h InstrD=%h required PCD=00000200",
                     found, pcd, instr);
        end
    endtask

    task automatic test_wrap_align();
        logic        found;
        logic [31:0] pcd, instr, p4;
        do_reset();
        lat_min = 1;
        lat_max = 1;
        ready_d = 1'b1;
        imem_bus.imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        settle();
        checks++;
        if (PC_Next !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_redirect PC_Next=%h required FFFFFFFC", PC_Next);
        end
        advance();
        redirect_valid = 1'b0;
        settle();
        checks++;
        if (imem_bus.imem_req_valid !== 1'b1 || imem_bus.imem_req_addr !== 32'hFFFF_FFFC ||
            PC_Next !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pc_next req_valid=%b addr=%h PC_Next=%h required 1/FFFFFFFC/0",
                     imem_bus.imem_req_valid, imem_bus.imem_req_addr, PC_Next);
        end
        advance();
        settle();
        advance();
        settle();
        checks++;
        if (valid_d !== 1'b1 || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pcplus4 valid_d=%b PCD=%h PCPlus4D=%h required 1/FFFFFFFC/0",
                     valid_d, PCD, PCPlus4D);
        end
        advance();
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0203;
        settle();
        checks++;
        if (PC_Next !== 32'h0000_0200) begin
            failures++;
            $display("FAIL align_pc_next PC_Next=%h required 00000200", PC_Next);
        end
        advance();
        redirect_valid = 1'b0;
        run_until_valid(found, pcd, instr, p4);
        checks++;
        if (!found || pcd !== 32'h200 || p4 !== 32'h204) begin
            failures++;
            $display("FAIL align_first_valid found=%b PCD=%h PCPlus4D=%h required 200/204",
                     found, pcd, p4);
        end
    endtask

    task automatic test_random();
        do_reset();
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(999, 0) == 0);
            ready_d = ($urandom_range(3, 0) != 0);
            imem_bus.imem_req_ready = ($urandom_range(9, 0) < 7);
            redirect_valid = ($urandom_range(24, 0) == 0);
            redirect_target = $urandom();
            settle();
            checks++;
            if (imem_bus.imem_req_valid !== exp_req_valid) begin
                failures++;
                $display("FAIL rnd_req_valid cyc=%0d got=%b required %b",
                         cyc, imem_bus.imem_req_valid, exp_req_valid);
            end
            checks++;
            if (imem_bus.imem_req_addr !== PC) begin
                failures++;
                $display("FAIL rnd_req_addr cyc=%0d got=%h required %h",
                         cyc, imem_bus.imem_req_addr, PC);
            end
            checks++;
            if (PC_Next !== exp_pc_next) begin
                failures++;
                $display("FAIL rnd_pc_next cyc=%0d got=%h required %h", cyc, PC_Next, exp_pc_next);
            end
            checks++;
            if (valid_d !== exp_valid_d) begin
                failures++;
                $display("FAIL rnd_valid_d cyc=%0d got=%b required %b", cyc, valid_d, exp_valid_d);
            end
            if (exp_valid_d) begin
                checks++;
                if (PCD !== exp_pcd || InstrD !== instr_of(exp_pcd) ||
                    PCPlus4D !== exp_pcd + 32'd4) begin
                    failures++;
                    $display("FAIL rnd_head cyc=%0d PCD=%h InstrD=%h PCPlus4D=%h required PCD=%h",
                             cyc, PCD, InstrD, PCPlus4D, exp_pcd);
                end
            end
            advance();
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        PC = 32'h40;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        ready_d = 1'b0;
        imem_bus.imem_req_ready = 1'b0;
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_stall_fill();
        test_redirect_flush();
        test_simultaneous();
        test_wrap_align();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
